bwt_req_arbiter: RTL and testbench
==================================

# bwt_req_arbiter

Shares the single paired-request path into the 200 MHz side of the request FIFO between several BWT lookup requesters, and routes the paired k/l responses back to the requester that issued them. It sits between the `Top` compute lanes and the two-write-port request FIFO and the k/l response FIFO pair. It arbitrates round-robin, limits the number of outstanding pairs, obeys the registered almost-full stall, and provides a flush/drain sequence used at batch end.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requester lanes (2..8)
- `ADDR_W`, 58, cache-line address width
- `TAG_W`, 6, per-request read-number tag width
- `MAX_OUT`, 8, maximum outstanding request pairs (power of two, ≤16); this is also the depth of the order FIFO

Ports:
- `CLK_200M` in 1: the only clock
- `spl_reset` in 1: asynchronous, active-high reset
- `stall` in 1: registered almost-full from the TX path
- `req_valid` in NUM_REQ: per-lane request pending
- `req_ready` out NUM_REQ: one-hot grant; a request transfers when both valid and ready are high
- `req_addr_k`, `req_addr_l` in NUM_REQ*ADDR_W: per-lane k and l line addresses; lane i occupies bits [i*ADDR_W +: ADDR_W]
- `req_tag` in NUM_REQ*TAG_W: per-lane read-number tag
- `out_valid` out 1: write enable for both request FIFO ports
- `out_addr_1`, `out_addr_2` out ADDR_W: k and l addresses
- `out_tag` out TAG_W: tag of the issued pair
- `rsp_both_valid` in 1: paired k/l response is present this cycle
- `rsp_k_data`, `rsp_l_data` in 512: response cache lines
- `rsp_valid` out NUM_REQ: one-hot response delivery
- `rsp_k`, `rsp_l` out 512; `rsp_tag` out TAG_W: delivered response and its tag
- `flush` in 1: stop granting and drain outstanding requests
- `flush_done` out 1: drain complete
- `outstanding` out 5: count of in-flight pairs
- `err_underflow` out 1: sticky flag; a response arrived with no pair outstanding

## Operation
- States are RUN, DRAIN and DONE. Reset enters RUN.
  - RUN → DRAIN when `flush` = 1.
  - DRAIN → DONE when `outstanding` = 0 and no pair is pending on `out_valid`.
  - DONE → RUN when `flush` = 0.
  - `flush_done` = 1 only in DONE.
- A grant is allowed only when all of these hold: state is RUN, `stall` = 0, `outstanding` < MAX_OUT, and the order FIFO is not full.
- When a grant is allowed, `req_ready` is driven combinationally for the winning lane. The winner is the lowest-indexed valid lane at or after the round-robin pointer, wrapping modulo NUM_REQ.
- On a transfer:
  - the pointer moves to winner+1, wrapping;
  - `{lane, tag}` is pushed into the order FIFO;
  - the addresses and tag are registered onto `out_*`.
- On `rsp_both_valid`:
  - the order FIFO is popped;
  - `rsp_k`, `rsp_l` and `rsp_tag` are registered;
  - the bit in `rsp_valid` for the popped lane is set for exactly one cycle.
- Responses return in issue order; no reordering is done.
- `outstanding` increments on a transfer and decrements on a response. If both happen in the same cycle, it is unchanged.
- If `rsp_both_valid` arrives while the order FIFO is empty:
  - `err_underflow` is set and stays set until reset;
  - the response is dropped, `rsp_valid` stays 0, and `outstanding` stays 0 with no wrap.
- `flush` arriving mid-transfer does not cancel the transfer already accepted in that cycle.
- Reset values: all outputs 0, pointer 0, order FIFO empty, state RUN.
- An asserted reset clears all in-flight bookkeeping immediately. Responses arriving afterward raise `err_underflow`.

## Timing
- Request latency: a transfer at edge N gives `out_valid` = 1 for cycle N+1. `out_valid` is never high on two cycles unless transfers occurred on two consecutive cycles.
- The maximum request rate is one pair per cycle.
- `stall` is sampled in the same cycle as the grant decision. Because of the registered output, at most one further pair can appear after `stall` rises.
- Response latency: `rsp_both_valid` at edge M gives `rsp_valid` for cycle M+1. `outstanding` reflects the pop from cycle M+1 onward.
- The `req_ready` paths from the combinational inputs `req_valid`, `stall` and `flush` are the only paths from input to output.

## Configuration
- `BWT_ARB_FIXED_PRIO_EN` defined: fixed priority, where lane 0 is highest and the pointer is unused and held at 0.
- Not defined: round-robin as described under Operation.
- All other behaviour is identical in both modes.

## Test plan
- **Round-robin fairness.** All 4 lanes hold `req_valid` with `stall` = 0 and responses returned immediately.
  - Grants follow lanes 0,1,2,3,0.
  - `out_addr_1` equals each lane's `req_addr_k` one cycle after its grant.
- **Credit limit.** Lane 2 streams requests with no responses.
  - Exactly 8 transfers occur, then `req_ready` = 0 and `outstanding` = 8.
  - One `rsp_both_valid` pulse gives `rsp_valid` = 4'b0100 and lets one more grant through.
- **Stall.** `stall` goes high after 3 grants.
  - No further `req_ready`; `out_valid` goes low after one cycle.
  - Granting resumes the cycle after `stall` = 0.
- **Simultaneous events.** A transfer and a response occur in the same cycle with `outstanding` = 5.
  - `outstanding` stays 5.
  - Responses come back in FIFO order with matching `rsp_tag` values (e.g. 6'd17 then 6'd18).
- **Flush.** Assert `flush` with 3 pairs outstanding.
  - No new grants are made.
  - `flush_done` rises one cycle after the third response.
  - Deasserting `flush` returns the block to RUN.
- **Underflow and reset.** Apply `rsp_both_valid` with nothing outstanding.
  - `err_underflow` = 1 and `rsp_valid` = 0.
  - Asynchronous `spl_reset` mid-stream clears all outputs within the same cycle.

Source files
------------

// File: rtl/bwt_req_arbiter_if.sv
// bwt_req_arbiter_if: request, response and control bundle between the BWT
// lookup lanes (master side) and the request arbiter (slave side).
interface bwt_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 58,
  parameter int TAG_W   = 6
);
  logic                      stall;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_k;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_l;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic                      out_valid;
  logic [ADDR_W-1:0]         out_addr_1;
  logic [ADDR_W-1:0]         out_addr_2;
  logic [TAG_W-1:0]          out_tag;
  logic                      rsp_both_valid;
  logic [511:0]              rsp_k_data;
  logic [511:0]              rsp_l_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [511:0]              rsp_k;
  logic [511:0]              rsp_l;
  logic [TAG_W-1:0]          rsp_tag;
  logic                      flush;
  logic                      flush_done;
  logic [4:0]                outstanding;
  logic                      err_underflow;

  modport master (
    output stall, req_valid, req_addr_k, req_addr_l, req_tag,
           rsp_both_valid, rsp_k_data, rsp_l_data, flush,
    input  req_ready, out_valid, out_addr_1, out_addr_2, out_tag,
           rsp_valid, rsp_k, rsp_l, rsp_tag, flush_done, outstanding, err_underflow
  );

  modport slave (
    input  stall, req_valid, req_addr_k, req_addr_l, req_tag,
           rsp_both_valid, rsp_k_data, rsp_l_data, flush,
    output req_ready, out_valid, out_addr_1, out_addr_2, out_tag,
           rsp_valid, rsp_k, rsp_l, rsp_tag, flush_done, outstanding, err_underflow
  );
endinterface

// File: rtl/bwt_req_arbiter.sv
// bwt_req_arbiter: shares the paired k/l request path into the request FIFO
// between NUM_REQ lookup lanes and routes paired responses back in issue order.
// An order FIFO of {lane, tag} remembers who issued each outstanding pair.
// Optional build macro BWT_ARB_FIXED_PRIO_EN selects fixed priority (lane 0
// highest) instead of the default round-robin.
module bwt_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 58,
  parameter int TAG_W   = 6,
  parameter int MAX_OUT = 8
) (
  input logic              CLK_200M,
  input logic              spl_reset,
  bwt_req_arbiter_if.slave bus
);

  localparam int LANE_W = $clog2(NUM_REQ);
  localparam int PTR_W  = $clog2(MAX_OUT);
  localparam int ENT_W  = LANE_W + TAG_W;
  localparam logic [4:0]        MAX_OUT_W = 5'(MAX_OUT);
  localparam logic [LANE_W:0]   NUM_LANES = (LANE_W + 1)'(NUM_REQ);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} arb_state_t;

  arb_state_t        state;
  logic [LANE_W-1:0] rr_ptr;
  logic [ENT_W-1:0]  order_mem [MAX_OUT];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              fifo_empty;
  logic              fifo_full;
  logic              grant_ok;
  logic              found;
  logic              xfer;
  logic              pop;
  logic              underflow;
  logic [LANE_W-1:0] win_lane;
  logic [LANE_W:0]   cand;
  logic [LANE_W-1:0] cand_lane;
  logic [LANE_W-1:0] head_lane;
  logic [TAG_W-1:0]  head_tag;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign {head_lane, head_tag} = order_mem[rd_ptr[PTR_W-1:0]];

  // Reset is folded in so req_ready is low while reset is asserted.
  assign grant_ok = !spl_reset && (state == RUN) && !bus.stall && !bus.flush &&
                    (bus.outstanding < MAX_OUT_W) && !fifo_full;
  assign xfer      = grant_ok && found;
  assign pop       = bus.rsp_both_valid && !fifo_empty;
  assign underflow = bus.rsp_both_valid && fifo_empty;

  // Pick the first valid lane at or after the pointer, wrapping around.
  always_comb begin
    found     = 1'b0;
    win_lane  = '0;
    cand      = '0;
    cand_lane = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, rr_ptr} + (LANE_W + 1)'(off);
      if (cand >= NUM_LANES) cand = cand - NUM_LANES;
      cand_lane = cand[LANE_W-1:0];
      if (!found && bus.req_valid[cand_lane]) begin
        found    = 1'b1;
        win_lane = cand_lane;
      end
    end
  end

  // One-hot ready for the winning lane when a grant is allowed.
  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready[win_lane] = 1'b1;
  end

  // Order FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge CLK_200M) begin
    if (xfer)
      order_mem[wr_ptr[PTR_W-1:0]] <= {win_lane, bus.req_tag[int'(win_lane) * TAG_W +: TAG_W]};
  end

  // Issue/response registers, in-flight bookkeeping and the flush state machine.
  always_ff @(posedge CLK_200M or posedge spl_reset) begin
    if (spl_reset) begin
      state             <= RUN;
      rr_ptr            <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      bus.outstanding   <= '0;
      bus.out_valid     <= 1'b0;
      bus.out_addr_1    <= '0;
      bus.out_addr_2    <= '0;
      bus.out_tag       <= '0;
      bus.rsp_valid     <= '0;
      bus.rsp_k         <= '0;
      bus.rsp_l         <= '0;
      bus.rsp_tag       <= '0;
      bus.flush_done    <= 1'b0;
      bus.err_underflow <= 1'b0;
    end else begin
      bus.out_valid <= xfer;
      if (xfer) begin
        bus.out_addr_1 <= bus.req_addr_k[int'(win_lane) * ADDR_W +: ADDR_W];
        bus.out_addr_2 <= bus.req_addr_l[int'(win_lane) * ADDR_W +: ADDR_W];
        bus.out_tag    <= bus.req_tag[int'(win_lane) * TAG_W +: TAG_W];
        wr_ptr         <= wr_ptr + 1'b1;
`ifdef BWT_ARB_FIXED_PRIO_EN
        rr_ptr         <= '0;
`else
        rr_ptr         <= (win_lane == LAST_LANE) ? '0 : win_lane + 1'b1;
`endif
      end

      bus.rsp_valid <= '0;
      if (pop) begin
        bus.rsp_valid[head_lane] <= 1'b1;
        bus.rsp_k                <= bus.rsp_k_data;
        bus.rsp_l                <= bus.rsp_l_data;
        bus.rsp_tag              <= head_tag;
        rd_ptr                   <= rd_ptr + 1'b1;
      end

      if (underflow) bus.err_underflow <= 1'b1;

      case ({xfer, pop})
        2'b10:   bus.outstanding <= bus.outstanding + 5'd1;
        2'b01:   bus.outstanding <= bus.outstanding - 5'd1;
        default: bus.outstanding <= bus.outstanding;
      endcase

      case (state)
        RUN: begin
          if (bus.flush) state <= DRAIN;
        end
        DRAIN: begin
          if ((bus.outstanding == 5'd0) && !bus.out_valid) begin
            state          <= DONE;
            bus.flush_done <= 1'b1;
          end
        end
        DONE: begin
          if (!bus.flush) begin
            state          <= RUN;
            bus.flush_done <= 1'b0;
          end
        end
        default: begin
          state          <= RUN;
          bus.flush_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bwt_req_arbiter.sv
// tb_bwt_req_arbiter: directed scoreboard bench for bwt_req_arbiter.
// Stimulus pushes expected issued pairs and expected responses into queues;
// two negedge monitors pop and compare whenever out_valid / rsp_valid show up.
module tb_bwt_req_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 58;
  localparam int TAG_W   = 6;
  localparam int MAX_OUT = 8;

  typedef struct {
    logic [ADDR_W-1:0] addr_k;
    logic [ADDR_W-1:0] addr_l;
    logic [TAG_W-1:0]  tag;
  } out_exp_t;

  typedef struct {
    logic [NUM_REQ-1:0] lane_oh;
    logic [TAG_W-1:0]   tag;
    logic [63:0]        k_lo;
    logic [63:0]        l_lo;
  } rsp_exp_t;

  typedef struct {
    int               lane;
    logic [TAG_W-1:0] tag;
  } order_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  out_exp_t          exp_out[$];
  rsp_exp_t          exp_rsp[$];
  order_t            order_q[$];
  logic [TAG_W-1:0]  lane_tag   [NUM_REQ];
  logic [ADDR_W-1:0] addr_k_tbl [NUM_REQ];
  logic [ADDR_W-1:0] addr_l_tbl [NUM_REQ];
  logic [63:0]       rsp_seq = 64'd0;

  bwt_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) bus ();

  bwt_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .CLK_200M  (clk),
    .spl_reset (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [63:0] actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s unexpected output actual=%0h expected=none", name, actual);
  endtask

  // Drive one cycle of inputs, check req_ready, update the scoreboard, step one edge.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic stall_i,
                               input logic flush_i, input logic rsp_i,
                               input logic [NUM_REQ-1:0] exp_ready, input string name);
    order_t ent;
    bus.req_valid      = valid;
    bus.stall          = stall_i;
    bus.flush          = flush_i;
    bus.rsp_both_valid = rsp_i;
    for (int i = 0; i < NUM_REQ; i++) bus.req_tag[i*TAG_W +: TAG_W] = lane_tag[i];
    bus.rsp_k_data = {448'd0, 64'hAAAA_0000_0000_0000 + rsp_seq};
    bus.rsp_l_data = {448'd0, 64'hBBBB_0000_0000_0000 + rsp_seq};
    #1;
    checkOutput({name, "_ready"}, 64'(bus.req_ready), 64'(exp_ready));
    if (rsp_i && order_q.size() > 0) begin
      ent = order_q.pop_front();
      exp_rsp.push_back('{lane_oh: NUM_REQ'(1) << ent.lane, tag: ent.tag,
                          k_lo: 64'hAAAA_0000_0000_0000 + rsp_seq,
                          l_lo: 64'hBBBB_0000_0000_0000 + rsp_seq});
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (exp_ready[i]) begin
        exp_out.push_back('{addr_k: addr_k_tbl[i], addr_l: addr_l_tbl[i], tag: lane_tag[i]});
        order_q.push_back('{lane: i, tag: lane_tag[i]});
      end
    end
    rsp_seq = rsp_seq + 64'd1;
    @(posedge clk);
    #1;
  endtask

  // Compare each issued pair against the oldest expected one.
  always @(negedge clk) begin : out_monitor
    out_exp_t eo;
    if (bus.out_valid === 1'b1) begin
      if (exp_out.size() == 0) reportUnexpected("out_valid", 64'(bus.out_addr_1));
      else begin
        eo = exp_out.pop_front();
        checkOutput("out_addr_1", 64'(bus.out_addr_1), 64'(eo.addr_k));
        checkOutput("out_addr_2", 64'(bus.out_addr_2), 64'(eo.addr_l));
        checkOutput("out_tag", 64'(bus.out_tag), 64'(eo.tag));
      end
    end
  end

  // Compare each delivered response against the oldest expected one.
  always @(negedge clk) begin : rsp_monitor
    rsp_exp_t er;
    if (bus.rsp_valid !== '0) begin
      if (exp_rsp.size() == 0) reportUnexpected("rsp_valid", 64'(bus.rsp_valid));
      else begin
        er = exp_rsp.pop_front();
        checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(er.lane_oh));
        checkOutput("rsp_tag", 64'(bus.rsp_tag), 64'(er.tag));
        checkOutput("rsp_k_lo", bus.rsp_k[63:0], er.k_lo);
        checkOutput("rsp_l_lo", bus.rsp_l[63:0], er.l_lo);
        checkOutput("rsp_k_hi", 64'(|bus.rsp_k[511:64]), 64'd0);
      end
    end
  end

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenario sequence.
  initial begin
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      lane_tag[i]   = TAG_W'(10 + i);
      addr_k_tbl[i] = 58'h100_0000_0000 + ADDR_W'(i) * 58'h1_0001;
      addr_l_tbl[i] = 58'h200_0000_0000 + ADDR_W'(i) * 58'h2_0003;
      bus.req_addr_k[i*ADDR_W +: ADDR_W] = addr_k_tbl[i];
      bus.req_addr_l[i*ADDR_W +: ADDR_W] = addr_l_tbl[i];
      bus.req_tag[i*TAG_W +: TAG_W]      = lane_tag[i];
    end
    bus.req_valid      = '1;
    bus.stall          = 1'b0;
    bus.flush          = 1'b0;
    bus.rsp_both_valid = 1'b0;
    bus.rsp_k_data     = '0;
    bus.rsp_l_data     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_outstanding", 64'(bus.outstanding), 64'd0);
    checkOutput("reset_flush_done", 64'(bus.flush_done), 64'd0);
    checkOutput("reset_err", 64'(bus.err_underflow), 64'd0);
    checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    rst = 1'b0;

    $display("[TB] round-robin fairness");
    applyStimulus(4'b1111, 0, 0, 0, 4'b0001, "rr0");
    applyStimulus(4'b1111, 0, 0, 1, 4'b0010, "rr1");
    applyStimulus(4'b1111, 0, 0, 1, 4'b0100, "rr2");
    applyStimulus(4'b1111, 0, 0, 1, 4'b1000, "rr3");
    applyStimulus(4'b1111, 0, 0, 1, 4'b0001, "rr4");
    applyStimulus(4'b0000, 0, 0, 1, 4'b0000, "rr_tail");
    checkOutput("rr_outstanding", 64'(bus.outstanding), 64'd0);

    $display("[TB] credit limit");
    repeat (8) applyStimulus(4'b0100, 0, 0, 0, 4'b0100, "credit_fill");
    checkOutput("credit_outstanding_full", 64'(bus.outstanding), 64'd8);
    applyStimulus(4'b0100, 0, 0, 1, 4'b0000, "credit_blocked");
    checkOutput("credit_outstanding_after_rsp", 64'(bus.outstanding), 64'd7);
    applyStimulus(4'b0100, 0, 0, 0, 4'b0100, "credit_refill");
    applyStimulus(4'b0100, 0, 0, 0, 4'b0000, "credit_blocked2");
    repeat (8) applyStimulus(4'b0000, 0, 0, 1, 4'b0000, "credit_drain");
    checkOutput("credit_outstanding_drained", 64'(bus.outstanding), 64'd0);

    $display("[TB] stall");
    applyStimulus(4'b1111, 0, 0, 0, 4'b1000, "stall_g0");
    applyStimulus(4'b1111, 0, 0, 0, 4'b0001, "stall_g1");
    applyStimulus(4'b1111, 0, 0, 0, 4'b0010, "stall_g2");
    checkOutput("stall_out_valid_last", 64'(bus.out_valid), 64'd1);
    applyStimulus(4'b1111, 1, 0, 0, 4'b0000, "stall_hold0");
    checkOutput("stall_out_valid_low", 64'(bus.out_valid), 64'd0);
    applyStimulus(4'b1111, 1, 0, 0, 4'b0000, "stall_hold1");
    applyStimulus(4'b1111, 0, 0, 0, 4'b0100, "stall_resume0");
    applyStimulus(4'b1111, 0, 0, 0, 4'b1000, "stall_resume1");
    checkOutput("stall_outstanding", 64'(bus.outstanding), 64'd5);

    $display("[TB] simultaneous transfer and response");
    lane_tag[0] = 6'd17;
    applyStimulus(4'b0001, 0, 0, 1, 4'b0001, "simul0");
    checkOutput("simul_outstanding0", 64'(bus.outstanding), 64'd5);
    lane_tag[0] = 6'd18;
    applyStimulus(4'b0001, 0, 0, 1, 4'b0001, "simul1");
    checkOutput("simul_outstanding1", 64'(bus.outstanding), 64'd5);
    repeat (5) applyStimulus(4'b0000, 0, 0, 1, 4'b0000, "simul_drain");
    checkOutput("simul_outstanding_drained", 64'(bus.outstanding), 64'd0);

    $display("[TB] flush");
    repeat (3) applyStimulus(4'b0010, 0, 0, 0, 4'b0010, "flush_fill");
    applyStimulus(4'b0010, 0, 1, 0, 4'b0000, "flush_start");
    repeat (3) applyStimulus(4'b0010, 0, 1, 1, 4'b0000, "flush_drain");
    checkOutput("flush_done_early", 64'(bus.flush_done), 64'd0);
    applyStimulus(4'b0010, 0, 1, 0, 4'b0000, "flush_wait");
    checkOutput("flush_done_set", 64'(bus.flush_done), 64'd1);
    applyStimulus(4'b0010, 0, 0, 0, 4'b0000, "flush_release");
    checkOutput("flush_done_clear", 64'(bus.flush_done), 64'd0);
    applyStimulus(4'b0010, 0, 0, 0, 4'b0010, "flush_back_to_run");
    applyStimulus(4'b0000, 0, 0, 1, 4'b0000, "flush_cleanup");
    checkOutput("flush_outstanding", 64'(bus.outstanding), 64'd0);
    checkOutput("err_before_underflow", 64'(bus.err_underflow), 64'd0);

    $display("[TB] underflow and reset");
    applyStimulus(4'b0000, 0, 0, 1, 4'b0000, "underflow");
    checkOutput("underflow_err", 64'(bus.err_underflow), 64'd1);
    checkOutput("underflow_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("underflow_outstanding", 64'(bus.outstanding), 64'd0);
    applyStimulus(4'b0000, 0, 0, 0, 4'b0000, "underflow_idle");
    checkOutput("underflow_err_sticky", 64'(bus.err_underflow), 64'd1);
    applyStimulus(4'b0001, 0, 0, 0, 4'b0001, "rst_grant");
    checkOutput("rst_pre_out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("rst_pre_outstanding", 64'(bus.outstanding), 64'd1);
    rst = 1'b1;
    #1;
    exp_out.delete();
    exp_rsp.delete();
    order_q.delete();
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_addr_1", 64'(bus.out_addr_1), 64'd0);
    checkOutput("rst_outstanding", 64'(bus.outstanding), 64'd0);
    checkOutput("rst_err", 64'(bus.err_underflow), 64'd0);
    checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(4'b0000, 0, 0, 1, 4'b0000, "post_rst_rsp");
    checkOutput("post_rst_err", 64'(bus.err_underflow), 64'd1);
    checkOutput("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);

    repeat (2) applyStimulus(4'b0000, 0, 0, 0, 4'b0000, "final_idle");
    checkOutput("exp_out_empty", 64'(exp_out.size()), 64'd0);
    checkOutput("exp_rsp_empty", 64'(exp_rsp.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
